tx_capture_hold: RTL and testbench

Multi-word successor to the single-word TX flag capture used on the REF_CLK domain. Each valid TX word is buffered in a small FIFO. Words are then presented one at a time on TX_send with vld held high for exactly HOLD_CYCLES cycles each. Back-to-back words stream without a vld gap. Overflow is flagged and counted instead of silently overwriting the held word.

---
 rtl/tx_capture_hold_if.sv | 27 ++
 rtl/tx_capture_hold.sv | 168 ++++++++++++++++
 tb/tb_tx_capture_hold.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_capture_hold_if.sv
// Bus bundle for tx_capture_hold: capture-side inputs and presentation-side
// status outputs. The producer drives through the master modport; the
// capture block sees the slave modport.
interface tx_capture_hold_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic [DATA_WIDTH-1:0] TX_IN;
    logic                  TX_VLD;
    logic                  CLR;
    logic [DATA_WIDTH-1:0] TX_send;
    logic                  vld;
    logic                  busy;
    logic [ADDR_WIDTH:0]   level;
    logic                  ovf;
    logic [7:0]            drop_cnt;

    modport master (
        output TX_IN, TX_VLD, CLR,
        input  TX_send, vld, busy, level, ovf, drop_cnt
    );

    modport slave (
        input  TX_IN, TX_VLD, CLR,
        output TX_send, vld, busy, level, ovf, drop_cnt
    );
endinterface

// File: rtl/tx_capture_hold.sv
// tx_capture_hold: buffers TX words in a small FIFO and presents each one on
// TX_send with vld held high for exactly HOLD_CYCLES cycles. Consecutive
// words stream without a vld gap; words arriving while the FIFO is full (and
// no pop happens at the same edge) are dropped, flagged and counted.
module tx_capture_hold #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic              REF_CLK,
    input  logic              RST_REF,
    tx_capture_hold_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_ZERO  = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic [CNT_WIDTH-1:0]  r_hold_cnt;
    logic [DATA_WIDTH-1:0] r_tx_send;
    logic                  r_vld;
    logic                  r_busy;
    logic                  r_ovf;
    logic [7:0]            r_drop_cnt;

    logic                  w_hold_done;
    logic                  w_push_req;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [ADDR_WIDTH:0]   w_level_nxt;
    logic                  w_vld_nxt;

    // Pop/push decisions from the pre-edge level; a full FIFO still accepts
    // a word when the head is popped at the same edge.
    always_comb begin
        w_hold_done = (r_hold_cnt == LAST_CNT);
        w_push_req  = bus.TX_VLD & ~bus.CLR;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = (r_level != LVL_ZERO);
            ST_HOLD: w_pop = w_hold_done && (r_level != LVL_ZERO);
            default: w_pop = 1'b0;
        endcase
        w_push = w_push_req && ((r_level != FULL_LVL) || w_pop);
        w_drop = w_push_req && !w_push;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_ONE;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_ONE;
        end else begin
            w_level_nxt = r_level;
        end
        if (w_pop) begin
            w_vld_nxt = 1'b1;
        end else if ((r_state == ST_HOLD) && !w_hold_done) begin
            w_vld_nxt = 1'b1;
        end else begin
            w_vld_nxt = 1'b0;
        end
    end

    // FIFO storage write; CLR already suppresses w_push.
    always_ff @(posedge REF_CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.TX_IN;
        end
    end

    // Presentation FSM, FIFO bookkeeping and drop accounting; CLR acts as a
    // synchronous copy of reset and wins over a same-cycle TX_VLD.
    always_ff @(posedge REF_CLK or negedge RST_REF) begin
        if (!RST_REF) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= LVL_ZERO;
            r_hold_cnt <= CNT_ZERO;
            r_tx_send  <= DATA_ZERO;
            r_vld      <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (bus.CLR) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= LVL_ZERO;
            r_hold_cnt <= CNT_ZERO;
            r_tx_send  <= DATA_ZERO;
            r_vld      <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level <= w_level_nxt;
            r_busy  <= w_vld_nxt | (w_level_nxt != LVL_ZERO);
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_send  <= r_mem[r_rd_ptr];
                        r_vld      <= 1'b1;
                        r_hold_cnt <= CNT_ZERO;
                        r_state    <= ST_HOLD;
                    end else begin
                        r_tx_send <= DATA_ZERO;
                        r_vld     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!w_hold_done) begin
                        r_hold_cnt <= r_hold_cnt + CNT_ONE;
                    end else if (w_pop) begin
                        // Next word takes over with no vld gap.
                        r_tx_send  <= r_mem[r_rd_ptr];
                        r_hold_cnt <= CNT_ZERO;
                    end else begin
                        r_tx_send  <= DATA_ZERO;
                        r_vld      <= 1'b0;
                        r_hold_cnt <= CNT_ZERO;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx_send  <= DATA_ZERO;
                    r_vld      <= 1'b0;
                    r_hold_cnt <= CNT_ZERO;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.TX_send  = r_tx_send;
    assign bus.vld      = r_vld;
    assign bus.busy     = r_busy;
    assign bus.level    = r_level;
    assign bus.ovf      = r_ovf;
    assign bus.drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_tx_capture_hold.sv
// Bench for tx_capture_hold: DUT A uses HOLD_CYCLES=16, DUT B HOLD_CYCLES=1.
// Expected words go into per-DUT queues; negedge monitors pop and compare.
module tb_tx_capture_hold;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tx_capture_hold_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_a ();
    tx_capture_hold_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_b ();

    tx_capture_hold #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .HOLD_CYCLES(16), .CNT_WIDTH(16))
        u_dut_a (.REF_CLK(clk), .RST_REF(rst_n), .bus(bus_a));
    tx_capture_hold #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .HOLD_CYCLES(1), .CNT_WIDTH(16))
        u_dut_b (.REF_CLK(clk), .RST_REF(rst_n), .bus(bus_b));

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int  cnt_a    = 0;
    int  cnt_b    = 0;
    bit  mon_a_en = 1'b1;

    // Monitor A: each queued word must be shown for exactly 16 cycles.
    always @(negedge clk) begin
        if (!rst_n || !mon_a_en) begin
            cnt_a = 0;
        end else if (bus_a.vld) begin
            vectors++;
            if (q_a.size() == 0) begin
                miscompares++;
                $display("FAIL mon_a_unexpected: TX_send=%h with vld=1, required no word", bus_a.TX_send);
            end else begin
                if (bus_a.TX_send !== q_a[0]) begin
                    miscompares++;
                    $display("FAIL mon_a_data: TX_send=%h, required %h", bus_a.TX_send, q_a[0]);
                end
                cnt_a++;
                if (cnt_a == 16) begin
                    q_a.delete(0);
                    cnt_a = 0;
                end
            end
        end else begin
            vectors++;
            if (cnt_a != 0 || bus_a.TX_send !== 8'h00) begin
                miscompares++;
                $display("FAIL mon_a_window: vld low after %0d cycles, TX_send=%h, required 16-cycle window and 00",
                         cnt_a, bus_a.TX_send);
            end
            cnt_a = 0;
        end
    end

    // Monitor B: each queued word must be shown for exactly 1 cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_b = 0;
        end else if (bus_b.vld) begin
            vectors++;
            if (q_b.size() == 0) begin
                miscompares++;
                $display("FAIL mon_b_unexpected: TX_send=%h with vld=1, required no word", bus_b.TX_send);
            end else begin
                if (bus_b.TX_send !== q_b[0]) begin
                    miscompares++;
                    $display("FAIL mon_b_data: TX_send=%h, required %h", bus_b.TX_send, q_b[0]);
                end
                q_b.delete(0);
            end
        end else if (bus_b.TX_send !== 8'h00) begin
            vectors++;
            miscompares++;
            $display("FAIL mon_b_idle: TX_send=%h with vld=0, required 00", bus_b.TX_send);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain_a(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (q_a.size() == 0 && !bus_a.vld) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (q_a.size() == 0 && !bus_a.vld) done = 1'b1;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL drain_a: %0d words still expected, vld=%b, required empty", q_a.size(), bus_a.vld);
        end
    endtask

    task automatic test_reset();
        bus_a.TX_IN = 8'h00; bus_a.TX_VLD = 1'b0; bus_a.CLR = 1'b0;
        bus_b.TX_IN = 8'h00; bus_b.TX_VLD = 1'b0; bus_b.CLR = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus_a.vld, bus_a.busy, bus_a.ovf, bus_a.level, bus_a.drop_cnt, bus_a.TX_send} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_a: vld=%b busy=%b ovf=%b level=%0d drop=%0d send=%h, required all 0",
                     bus_a.vld, bus_a.busy, bus_a.ovf, bus_a.level, bus_a.drop_cnt, bus_a.TX_send);
        end
        vectors++;
        if ({bus_b.vld, bus_b.busy, bus_b.ovf, bus_b.level, bus_b.drop_cnt, bus_b.TX_send} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_b: vld=%b level=%0d drop=%0d send=%h, required all 0",
                     bus_b.vld, bus_b.level, bus_b.drop_cnt, bus_b.TX_send);
        end
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single();
        bus_a.TX_IN = 8'hA5; bus_a.TX_VLD = 1'b1; q_a.push_back(8'hA5);
        tick();                                   // edge 0: push
        bus_a.TX_VLD = 1'b0; bus_a.TX_IN = 8'h3C; // ignored while TX_VLD=0
        vectors++;
        if (bus_a.vld !== 1'b0 || bus_a.level !== 3'd1 || bus_a.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_pre: vld=%b level=%0d busy=%b, required 0/1/1", bus_a.vld, bus_a.level, bus_a.busy);
        end
        tick();                                   // edge 1: pop
        vectors++;
        if (bus_a.vld !== 1'b1 || bus_a.TX_send !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_first: vld=%b send=%h, required 1/a5", bus_a.vld, bus_a.TX_send);
        end
        repeat (15) tick();                       // edge 16
        vectors++;
        if (bus_a.vld !== 1'b1 || bus_a.TX_send !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_last: vld=%b send=%h, required 1/a5", bus_a.vld, bus_a.TX_send);
        end
        tick();                                   // edge 17: window ends
        vectors++;
        if (bus_a.vld !== 1'b0 || bus_a.TX_send !== 8'h00 || bus_a.busy !== 1'b0 || bus_a.level !== 3'd0) begin
            miscompares++;
            $display("FAIL single_end: vld=%b send=%h busy=%b level=%0d, required 0/00/0/0",
                     bus_a.vld, bus_a.TX_send, bus_a.busy, bus_a.level);
        end
        wait_drain_a(4);
    endtask

    task automatic test_burst();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        int highs = 0;
        for (int i = 0; i < 3; i++) begin
            bus_a.TX_IN = words[i]; bus_a.TX_VLD = 1'b1; q_a.push_back(words[i]);
            tick();                               // edges 0,1,2
            if (i >= 1 && bus_a.vld) highs++;
        end
        bus_a.TX_VLD = 1'b0;
        vectors++;
        if (bus_a.level !== 3'd2) begin
            miscompares++;
            $display("FAIL burst_level_peak: level=%0d, required 2", bus_a.level);
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus_a.vld) highs++;
            else break;
        end
        vectors++;
        if (highs != 48) begin
            miscompares++;
            $display("FAIL burst_vld_run: vld high for %0d cycles, required 48", highs);
        end
        wait_drain_a(8);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 5; i++) begin
            bus_a.TX_IN = 8'hC1 + 8'(i); bus_a.TX_VLD = 1'b1; q_a.push_back(8'hC1 + 8'(i));
            tick();                               // edges 0..4
        end
        bus_a.TX_VLD = 1'b0;
        repeat (12) tick();                       // edges 5..16
        vectors++;
        if (bus_a.level !== 3'd4 || bus_a.vld !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pop_pre: level=%0d vld=%b, required 4/1", bus_a.level, bus_a.vld);
        end
        bus_a.TX_IN = 8'h5A; bus_a.TX_VLD = 1'b1; q_a.push_back(8'h5A);
        tick();                                   // edge 17: pop + push while full
        bus_a.TX_VLD = 1'b0;
        vectors++;
        if (bus_a.level !== 3'd4 || bus_a.ovf !== 1'b0 || bus_a.drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL full_pop_accept: level=%0d ovf=%b drop=%0d, required 4/0/0",
                     bus_a.level, bus_a.ovf, bus_a.drop_cnt);
        end
        wait_drain_a(120);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 7; i++) begin
            bus_a.TX_IN = 8'(i); bus_a.TX_VLD = 1'b1;
            if (i <= 5) q_a.push_back(8'(i));
            tick();                               // edges 0..6
        end
        bus_a.TX_VLD = 1'b0;
        vectors++;
        if (bus_a.ovf !== 1'b1 || bus_a.drop_cnt !== 8'd2 || bus_a.level !== 3'd4) begin
            miscompares++;
            $display("FAIL ovf_first: ovf=%b drop=%0d level=%0d, required 1/2/4",
                     bus_a.ovf, bus_a.drop_cnt, bus_a.level);
        end
        wait_drain_a(120);
        mon_a_en = 1'b0;
        bus_a.TX_IN = 8'hEE; bus_a.TX_VLD = 1'b1;
        repeat (300) tick();
        bus_a.TX_VLD = 1'b0;
        vectors++;
        if (bus_a.drop_cnt !== 8'd255 || bus_a.ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_saturate: drop=%0d ovf=%b, required 255/1", bus_a.drop_cnt, bus_a.ovf);
        end
        bus_a.CLR = 1'b1;
        tick();
        bus_a.CLR = 1'b0;
        q_a.delete();
        cnt_a = 0;
        mon_a_en = 1'b1;
        vectors++;
        if (bus_a.drop_cnt !== 8'd0 || bus_a.ovf !== 1'b0 || bus_a.level !== 3'd0 || bus_a.vld !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: drop=%0d ovf=%b level=%0d vld=%b, required 0/0/0/0",
                     bus_a.drop_cnt, bus_a.ovf, bus_a.level, bus_a.vld);
        end
        tick();
    endtask

    task automatic test_clr_mid_hold();
        for (int i = 0; i < 3; i++) begin
            bus_a.TX_IN = 8'hD1 + 8'(i); bus_a.TX_VLD = 1'b1; q_a.push_back(8'hD1 + 8'(i));
            tick();                               // edges 0..2
        end
        bus_a.TX_VLD = 1'b0;
        repeat (6) tick();                        // edges 3..8: hold_cnt=7
        vectors++;
        if (bus_a.level !== 3'd2 || bus_a.vld !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_pre: level=%0d vld=%b, required 2/1", bus_a.level, bus_a.vld);
        end
        bus_a.CLR = 1'b1; bus_a.TX_VLD = 1'b1; bus_a.TX_IN = 8'h77;
        tick();                                   // edge 9: clear wins
        bus_a.CLR = 1'b0; bus_a.TX_VLD = 1'b0;
        q_a.delete();
        cnt_a = 0;
        vectors++;
        if (bus_a.vld !== 1'b0 || bus_a.TX_send !== 8'h00 || bus_a.level !== 3'd0 ||
            bus_a.ovf !== 1'b0 || bus_a.drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL clr_state: vld=%b send=%h level=%0d ovf=%b drop=%0d, required 0/00/0/0/0",
                     bus_a.vld, bus_a.TX_send, bus_a.level, bus_a.ovf, bus_a.drop_cnt);
        end
        repeat (20) tick();
        vectors++;
        if (bus_a.vld !== 1'b0 || bus_a.level !== 3'd0) begin
            miscompares++;
            $display("FAIL clr_discard: vld=%b level=%0d, required 0/0", bus_a.vld, bus_a.level);
        end
    endtask

    task automatic test_async_reset();
        bus_a.TX_IN = 8'h99; bus_a.TX_VLD = 1'b1; q_a.push_back(8'h99);
        tick();
        bus_a.TX_VLD = 1'b0;
        repeat (5) tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus_a.vld !== 1'b0 || bus_a.TX_send !== 8'h00 || bus_a.level !== 3'd0 || bus_a.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: vld=%b send=%h level=%0d busy=%b, required 0/00/0/0",
                     bus_a.vld, bus_a.TX_send, bus_a.level, bus_a.busy);
        end
        q_a.delete();
        cnt_a = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_single();
    endtask

    task automatic test_hold1_burst();
        logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
        bit ok;
        bus_b.TX_IN = words[0]; bus_b.TX_VLD = 1'b1; q_b.push_back(words[0]);
        tick();                                   // edge 0
        vectors++;
        if (bus_b.vld !== 1'b0) begin
            miscompares++;
            $display("FAIL h1_pre: vld=%b, required 0", bus_b.vld);
        end
        for (int i = 1; i < 4; i++) begin
            if (i < 3) begin
                bus_b.TX_IN = words[i]; q_b.push_back(words[i]);
            end else begin
                bus_b.TX_VLD = 1'b0;
            end
            tick();                               // edges 1..3
            vectors++;
            if (bus_b.vld !== 1'b1 || bus_b.TX_send !== words[i-1]) begin
                miscompares++;
                $display("FAIL h1_word%0d: vld=%b send=%h, required 1/%h", i, bus_b.vld, bus_b.TX_send, words[i-1]);
            end
        end
        tick();                                   // edge 4
        vectors++;
        if (bus_b.vld !== 1'b0 || bus_b.busy !== 1'b0 || bus_b.level !== 3'd0) begin
            miscompares++;
            $display("FAIL h1_end: vld=%b busy=%b level=%0d, required 0/0/0", bus_b.vld, bus_b.busy, bus_b.level);
        end
        for (int i = 0; i < 8; i++) begin
            bus_b.TX_IN = 8'h40 + 8'(i); bus_b.TX_VLD = 1'b1; q_b.push_back(8'h40 + 8'(i));
            tick();
        end
        bus_b.TX_VLD = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (q_b.size() == 0 && !bus_b.vld) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok || bus_b.ovf !== 1'b0 || bus_b.drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL h1_stream: pending=%0d ovf=%b drop=%0d, required 0/0/0", q_b.size(), bus_b.ovf, bus_b.drop_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_pop();
        test_overflow();
        test_clr_mid_hold();
        test_async_reset();
        test_hold1_burst();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
